// File: rtl/mult_err_pkg.sv
// Shared definitions for the multiplier error accumulator:
// the FSM state encoding, default sizes and the width helpers for derived widths.
package mult_err_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_NSAMP = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sample/mismatch counter width: must hold the value NSAMP itself.
  function automatic int cnt_w(input int nsamp);
    return $clog2(nsamp + 1);
  endfunction

  // |error| sum width: NSAMP worst-case errors of 2W bits each cannot overflow.
  function automatic int sum_w(input int w, input int nsamp);
    return 2 * w + $clog2(nsamp);
  endfunction

endpackage

// File: rtl/mult_abs_diff.sv
// Combinational error of an approximate product against its reference:
// the signed difference at full 2W+1 precision, its magnitude and a mismatch flag.
module mult_abs_diff #(
  parameter int W = 8
) (
  input  logic [2*W-1:0]        p_apx,
  input  logic [2*W-1:0]        p_ref,
  output logic [2*W-1:0]        abs_err,
  output logic                  neq,
  output logic signed [2*W:0]   sgn_err
);

  localparam int PW = 2 * W;

  // Difference is widened by one bit so neither the sign nor the magnitude is lost.
  always_comb begin
    sgn_err = $signed({1'b0, p_apx}) - $signed({1'b0, p_ref});
    abs_err = sgn_err[PW] ? PW'(-sgn_err) : sgn_err[PW-1:0];
    neq     = (p_apx != p_ref);
  end

endmodule

// File: rtl/mult_err_accum.sv
// Error-metric accumulator for an accurate/approximate 8x8 multiplier pair.
// Over a window of NSAMP accepted samples it gathers mismatch count, sum of
// |error|, max |error| with the operands that first produced it, and presents
// the results through a done/ack handshake.
// Optional build macro MULT_ERR_BIAS_EN adds a signed error accumulator on
// sum_sgn_err; without it that port is tied to zero.
module mult_err_accum
  import mult_err_pkg::*;
#(
  parameter  int W     = DEF_W,
  parameter  int NSAMP = DEF_NSAMP,
  localparam int CNT_W = cnt_w(NSAMP),
  localparam int SUM_W = sum_w(W, NSAMP)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
  input  logic [2*W-1:0]          p_apx,
  input  logic [2*W-1:0]          p_ref,
  output logic                    done_valid,
  input  logic                    done_ack,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [SUM_W-1:0]        sum_abs_err,
  output logic [2*W-1:0]          max_abs_err,
  output logic [W-1:0]            max_a,
  output logic [W-1:0]            max_b,
  output logic signed [SUM_W:0]   sum_sgn_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSAMP - 1);

  state_t                 state_p1;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       smp_cnt_p1;
  logic                   vld_p0;
  logic                   last_p0;
  logic                   clr_p0;
  logic [2*W-1:0]         abs_err_p0;
  logic                   neq_p0;
  logic signed [2*W:0]    sgn_err_p0;

  assign vld_p0  = in_valid & in_ready;
  assign last_p0 = (smp_cnt_p1 == LAST);
  // A window opens from IDLE, or straight from DONE when ack and start coincide.
  assign clr_p0  = start & ((state_p1 == IDLE) | ((state_p1 == DONE) & done_ack));

  mult_abs_diff #(.W(W)) u_abs_diff (
    .p_apx   (p_apx),
    .p_ref   (p_ref),
    .abs_err (abs_err_p0),
    .neq     (neq_p0),
    .sgn_err (sgn_err_p0)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_p1 <= IDLE;
    else     state_p1 <= state_nxt;
  end

  // Next-state logic; start is ignored in RUN and in DONE without ack.
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (vld_p0 && last_p0) state_nxt = DONE;
      DONE:    if (done_ack) state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready   = (state_p1 == RUN);
    done_valid = (state_p1 == DONE);
  end

  // Sample counter and unsigned metrics; results hold outside RUN until the next window.
  always_ff @(posedge clk) begin
    if (rst || clr_p0) begin
      smp_cnt_p1  <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_a       <= '0;
      max_b       <= '0;
    end else if (vld_p0) begin
      smp_cnt_p1  <= smp_cnt_p1 + CNT_W'(1);
      if (neq_p0) err_cnt <= err_cnt + CNT_W'(1);
      sum_abs_err <= sum_abs_err + SUM_W'(abs_err_p0);
      // Strict compare keeps the operands of the earliest sample on ties.
      if (abs_err_p0 > max_abs_err) begin
        max_abs_err <= abs_err_p0;
        max_a       <= a;
        max_b       <= b;
      end
    end
  end

`ifdef MULT_ERR_BIAS_EN
  // Signed error sum exposes systematic bias of the approximate multiplier.
  always_ff @(posedge clk) begin
    if (rst || clr_p0)  sum_sgn_err <= '0;
    else if (vld_p0)    sum_sgn_err <= sum_sgn_err + (SUM_W + 1)'(sgn_err_p0);
  end
`else
  assign sum_sgn_err = '0;
`endif

endmodule
